// File: rtl/debug_burst_sequencer_if.sv
// debug_burst_sequencer_if: groups the command, bus, response and breakpoint
// signals of the debug burst sequencer.
// The "slave" modport is the sequencer's view.
// The "master" modport is the view of the environment that drives commands,
// answers bus transfers and consumes responses.
interface debug_burst_sequencer_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 8
);
  // command handshake
  logic                   CMD_VALID_I;
  logic                   CMD_READY_O;
  logic [2:0]             CMD_OP_I;
  logic [2:0]             CMD_ARG_I;
  logic [ADDR_WIDTH-1:0]  CMD_ADDR_I;
  logic [DATA_WIDTH-1:0]  CMD_DATA_I;
  logic [COUNT_WIDTH-1:0] CMD_COUNT_I;
  logic                   CMD_ADDR_INC_I;
  // CPU bus side
  logic                   BUS_REQ_O;
  logic                   BUS_WE_O;
  logic [ADDR_WIDTH-1:0]  BUS_ADDR_O;
  logic [DATA_WIDTH-1:0]  BUS_DOUT_O;
  logic [DATA_WIDTH-1:0]  BUS_DIN_I;
  logic                   BUS_ACK_I;
  // read response handshake
  logic                   RSP_VALID_O;
  logic [DATA_WIDTH-1:0]  RSP_DATA_O;
  logic                   RSP_READY_I;
  // breakpoint and status
  logic [ADDR_WIDTH-1:0]  PC_I;
  logic                   BKP_HIT_O;
  logic                   BUSY_O;
  logic                   ERR_O;

  modport slave (
    input  CMD_VALID_I, CMD_OP_I, CMD_ARG_I, CMD_ADDR_I, CMD_DATA_I,
           CMD_COUNT_I, CMD_ADDR_INC_I, BUS_DIN_I, BUS_ACK_I, RSP_READY_I, PC_I,
    output CMD_READY_O, BUS_REQ_O, BUS_WE_O, BUS_ADDR_O, BUS_DOUT_O,
           RSP_VALID_O, RSP_DATA_O, BKP_HIT_O, BUSY_O, ERR_O
  );

  modport master (
    output CMD_VALID_I, CMD_OP_I, CMD_ARG_I, CMD_ADDR_I, CMD_DATA_I,
           CMD_COUNT_I, CMD_ADDR_INC_I, BUS_DIN_I, BUS_ACK_I, RSP_READY_I, PC_I,
    input  CMD_READY_O, BUS_REQ_O, BUS_WE_O, BUS_ADDR_O, BUS_DOUT_O,
           RSP_VALID_O, RSP_DATA_O, BKP_HIT_O, BUSY_O, ERR_O
  );
endinterface

// File: rtl/debug_burst_sequencer.sv
// debug_burst_sequencer: accepts one debug command per handshake.
// It runs memory read/write bursts with optional address auto-increment and
// returns read data through a response handshake.
// It also owns a breakpoint table that is compared against the CPU PC.
//
// Optional feature: when the macro DEBUG_SEQ_BUS_TIMEOUT_EN is defined, a bus
// transfer that sees no ACK for 63 cycles is abandoned and ERR_O is raised.
// Without the macro, BUS waits for ACK indefinitely.
module debug_burst_sequencer #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_BKP     = 4,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  debug_burst_sequencer_if.slave  dbg
);

  localparam logic [2:0] OP_WR_BKP  = 3'd1;
  localparam logic [2:0] OP_CLR_BKP = 3'd2;
  localparam logic [2:0] OP_RD_MEM  = 3'd3;
  localparam logic [2:0] OP_WR_MEM  = 3'd4;
  localparam logic [3:0] NUM_BKP_L  = 4'(NUM_BKP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [COUNT_WIDTH-1:0]  r_count;
  logic                    r_inc;
  logic                    r_we;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_data;
  logic [NUM_BKP-1:0]      r_bkp_en;
  logic [ADDR_WIDTH-1:0]   r_bkp_addr [NUM_BKP];
  logic                    r_hit;
  logic                    r_err;

  logic                    w_accept;
  logic                    w_mem_cmd;
  logic                    w_bkp_cmd;
  logic                    w_slot_ok;
  logic                    w_last;
  logic                    w_bus_ack;
  logic                    w_rsp_take;
  logic                    w_advance;
  logic                    w_hit;
  logic                    w_timeout;
  logic                    w_cmd_ready;
  logic                    w_bus_req;
  logic                    w_busy;

  assign w_accept   = dbg.CMD_VALID_I && (r_state == ST_IDLE);
  assign w_mem_cmd  = (dbg.CMD_OP_I == OP_RD_MEM) || (dbg.CMD_OP_I == OP_WR_MEM);
  assign w_bkp_cmd  = (dbg.CMD_OP_I == OP_WR_BKP) || (dbg.CMD_OP_I == OP_CLR_BKP);
  assign w_slot_ok  = ({1'b0, dbg.CMD_ARG_I} < NUM_BKP_L);
  assign w_last     = (r_count == '0);
  assign w_bus_ack  = (r_state == ST_BUS) && dbg.BUS_ACK_I;
  assign w_rsp_take = (r_state == ST_RESP) && dbg.RSP_READY_I;
  // another beat follows: a write ACK or a consumed read response with count left
  assign w_advance  = ((w_bus_ack && r_we) || w_rsp_take) && !w_last;

`ifdef DEBUG_SEQ_BUS_TIMEOUT_EN
  logic [5:0] r_to_cnt;

  // bus watchdog: counts BUS cycles without ACK, restarts on ACK or on BUS entry
  always_ff @(posedge CLK) begin
    if (RESET || (r_state != ST_BUS) || dbg.BUS_ACK_I) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 6'd1;
    end
  end

  assign w_timeout = (r_state == ST_BUS) && !dbg.BUS_ACK_I && (r_to_cnt == 6'd63);
`else
  assign w_timeout = 1'b0;
`endif

  // state register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = 1'b0;
    w_bus_req   = 1'b0;
    w_busy      = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        w_cmd_ready = 1'b1;
        w_busy      = 1'b0;
        if (w_accept && w_mem_cmd) begin
          w_state_nxt = ST_BUS;
        end
      end
      ST_BUS: begin
        w_bus_req = 1'b1;
        if (w_timeout) begin
          w_state_nxt = ST_IDLE;
        end else if (dbg.BUS_ACK_I) begin
          if (!r_we) begin
            w_state_nxt = ST_RESP;
          end else if (w_last) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_RESP: begin
        if (dbg.RSP_READY_I) begin
          w_state_nxt = w_last ? ST_IDLE : ST_BUS;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // burst latches: loaded on accept, stepped after each completed beat
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_count <= '0;
      r_inc   <= 1'b0;
      r_we    <= 1'b0;
    end else if (w_accept && w_mem_cmd) begin
      r_addr  <= dbg.CMD_ADDR_I;
      r_data  <= dbg.CMD_DATA_I;
      r_count <= dbg.CMD_COUNT_I;
      r_inc   <= dbg.CMD_ADDR_INC_I;
      r_we    <= (dbg.CMD_OP_I == OP_WR_MEM);
    end else if (w_advance) begin
      r_count <= r_count - COUNT_WIDTH'(1);
      r_addr  <= r_addr + {{(ADDR_WIDTH-1){1'b0}}, r_inc};
    end
  end

  // read response: captured on a read ACK, held until the consumer takes it
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else if (w_bus_ack && !r_we) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= dbg.BUS_DIN_I;
    end else if (w_rsp_take) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // breakpoint table; an out-of-range slot index matches no loop iteration
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_BKP; i++) begin
      if (RESET) begin
        r_bkp_en[i]   <= 1'b0;
        r_bkp_addr[i] <= '0;
      end else if (w_accept && (3'(i) == dbg.CMD_ARG_I)) begin
        if (dbg.CMD_OP_I == OP_WR_BKP) begin
          r_bkp_en[i]   <= 1'b1;
          r_bkp_addr[i] <= dbg.CMD_ADDR_I;
        end else if (dbg.CMD_OP_I == OP_CLR_BKP) begin
          r_bkp_en[i]   <= 1'b0;
        end
      end
    end
  end

  // PC comparator over all enabled slots
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < NUM_BKP; i++) begin
      if (r_bkp_en[i] && (r_bkp_addr[i] == dbg.PC_I)) begin
        w_hit = 1'b1;
      end
    end
  end

  // registered breakpoint hit
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_hit <= 1'b0;
    end else begin
      r_hit <= w_hit;
    end
  end

  // sticky error: bad slot index or bus timeout, cleared by the next good accept
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end else if (w_accept) begin
      r_err <= w_bkp_cmd && !w_slot_ok;
    end
  end

  assign dbg.CMD_READY_O = w_cmd_ready;
  assign dbg.BUS_REQ_O   = w_bus_req;
  assign dbg.BUS_WE_O    = w_bus_req && r_we;
  assign dbg.BUS_ADDR_O  = r_addr;
  assign dbg.BUS_DOUT_O  = r_data;
  assign dbg.RSP_VALID_O = r_rsp_valid;
  assign dbg.RSP_DATA_O  = r_rsp_data;
  assign dbg.BKP_HIT_O   = r_hit;
  assign dbg.BUSY_O      = w_busy;
  assign dbg.ERR_O       = r_err;

endmodule

// File: tb/tb_debug_burst_sequencer.sv
// tb_debug_burst_sequencer: directed stimulus with a scoreboard.
// Expected bus beats and responses are queued when a command is issued.
// A monitor pops and compares them whenever the DUT presents a transfer.
`timescale 1ns/1ps
module tb_debug_burst_sequencer;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int NB = 4;
  localparam int CW = 8;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_WR_BKP  = 3'd1;
  localparam logic [2:0] OP_CLR_BKP = 3'd2;
  localparam logic [2:0] OP_RD_MEM  = 3'd3;
  localparam logic [2:0] OP_WR_MEM  = 3'd4;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  debug_burst_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dif ();

  debug_burst_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BKP(NB), .COUNT_WIDTH(CW)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .dbg   (dif)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout;
  } bus_exp_t;

  int            checks = 0;
  int            errors = 0;
  bus_exp_t      bus_q[$];
  logic [DW-1:0] rsp_q[$];
  logic [DW-1:0] rd_q[$];
  logic          ack_en = 1'b1;
  bus_exp_t      mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // bus responder: zero-wait ACK while enabled, read data from rd_q
  always @(negedge CLK) begin
    dif.BUS_ACK_I = dif.BUS_REQ_O && ack_en;
    if (dif.BUS_ACK_I && !dif.BUS_WE_O && (rd_q.size() > 0)) begin
      dif.BUS_DIN_I = rd_q.pop_front();
    end
  end

  // monitor: scoreboard compare of bus beats and responses
  always @(negedge CLK) begin
    #2;
    if (!RESET) begin
      if (dif.BUS_REQ_O && dif.BUS_ACK_I) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected addr=0x%0h we=%0b expected no transfer",
                   dif.BUS_ADDR_O, dif.BUS_WE_O);
        end else begin
          mon_e = bus_q.pop_front();
          chk("bus_we", {31'd0, dif.BUS_WE_O}, {31'd0, mon_e.we});
          chk("bus_addr", {16'd0, dif.BUS_ADDR_O}, {16'd0, mon_e.addr});
          if (mon_e.we) begin
            chk("bus_dout", {16'd0, dif.BUS_DOUT_O}, {16'd0, mon_e.dout});
          end
        end
      end
      if (dif.RSP_VALID_O) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected data=0x%0h expected no response", dif.RSP_DATA_O);
        end else begin
          chk("rsp_data", {16'd0, dif.RSP_DATA_O}, {16'd0, rsp_q[0]});
          if (dif.RSP_READY_I) begin
            void'(rsp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic send_cmd(input logic [2:0] op, input logic [2:0] arg,
                          input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [CW-1:0] cnt, input logic inc);
    int n;
    @(negedge CLK);
    dif.CMD_OP_I       = op;
    dif.CMD_ARG_I      = arg;
    dif.CMD_ADDR_I     = addr;
    dif.CMD_DATA_I     = data;
    dif.CMD_COUNT_I    = cnt;
    dif.CMD_ADDR_INC_I = inc;
    dif.CMD_VALID_I    = 1'b1;
    n = 0;
    while (!dif.CMD_READY_O && (n < 200)) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout ready=%0b required=1", dif.CMD_READY_O);
    end
    @(posedge CLK);
    #1;
    dif.CMD_VALID_I = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    @(negedge CLK);
    while (dif.BUSY_O && (n < maxc)) begin
      @(negedge CLK);
      n++;
    end
    if (n >= maxc) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout busy=%0b required=0", dif.BUSY_O);
    end
  endtask

  task automatic take_rsp(input int delay);
    int n;
    n = 0;
    @(negedge CLK);
    while (!dif.RSP_VALID_O && (n < 100)) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL rsp_wait_timeout valid=%0b required=1", dif.RSP_VALID_O);
    end
    repeat (delay) @(negedge CLK);
    dif.RSP_READY_I = 1'b1;
    @(negedge CLK);
    dif.RSP_READY_I = 1'b0;
  endtask

  initial begin
    dif.CMD_VALID_I    = 1'b0;
    dif.CMD_OP_I       = OP_NOP;
    dif.CMD_ARG_I      = 3'd0;
    dif.CMD_ADDR_I     = '0;
    dif.CMD_DATA_I     = '0;
    dif.CMD_COUNT_I    = '0;
    dif.CMD_ADDR_INC_I = 1'b0;
    dif.BUS_DIN_I      = '0;
    dif.BUS_ACK_I      = 1'b0;
    dif.RSP_READY_I    = 1'b0;
    dif.PC_I           = 16'h0000;

    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_ready",     {31'd0, dif.CMD_READY_O}, 32'd1);
    chk("rst_busy",      {31'd0, dif.BUSY_O},      32'd0);
    chk("rst_hit",       {31'd0, dif.BKP_HIT_O},   32'd0);
    chk("rst_err",       {31'd0, dif.ERR_O},       32'd0);
    chk("rst_req",       {31'd0, dif.BUS_REQ_O},   32'd0);
    chk("rst_rsp_valid", {31'd0, dif.RSP_VALID_O}, 32'd0);

    // breakpoints
    send_cmd(OP_WR_BKP, 3'd2, 16'h1234, 16'h0, 8'd0, 1'b0);
    dif.PC_I = 16'h1234;
    repeat (2) @(negedge CLK);
    chk("bkp_hit_set", {31'd0, dif.BKP_HIT_O}, 32'd1);
    chk("bkp_err_ok",  {31'd0, dif.ERR_O},     32'd0);
    chk("bkp_busy",    {31'd0, dif.BUSY_O},    32'd0);
    dif.PC_I = 16'h1235;
    repeat (2) @(negedge CLK);
    chk("bkp_pc_miss", {31'd0, dif.BKP_HIT_O}, 32'd0);
    dif.PC_I = 16'h1234;
    send_cmd(OP_CLR_BKP, 3'd2, 16'h0, 16'h0, 8'd0, 1'b0);
    repeat (2) @(negedge CLK);
    chk("bkp_cleared", {31'd0, dif.BKP_HIT_O}, 32'd0);
    send_cmd(OP_WR_BKP, 3'd5, 16'h1234, 16'h0, 8'd0, 1'b0);
    @(negedge CLK);
    chk("bad_slot_err", {31'd0, dif.ERR_O}, 32'd1);
    @(negedge CLK);
    chk("bad_slot_nohit", {31'd0, dif.BKP_HIT_O}, 32'd0);
    send_cmd(OP_NOP, 3'd0, 16'h0, 16'h0, 8'd0, 1'b0);
    @(negedge CLK);
    chk("nop_clr_err", {31'd0, dif.ERR_O},  32'd0);
    chk("nop_idle",    {31'd0, dif.BUSY_O}, 32'd0);

    // write burst crossing the address wrap
    bus_q.push_back('{we: 1'b1, addr: 16'hFFFE, dout: 16'hA5A5});
    bus_q.push_back('{we: 1'b1, addr: 16'hFFFF, dout: 16'hA5A5});
    bus_q.push_back('{we: 1'b1, addr: 16'h0000, dout: 16'hA5A5});
    bus_q.push_back('{we: 1'b1, addr: 16'h0001, dout: 16'hA5A5});
    send_cmd(OP_WR_MEM, 3'd0, 16'hFFFE, 16'hA5A5, 8'd3, 1'b1);
    chk("wr_busy", {31'd0, dif.BUSY_O}, 32'd1);
    wait_idle(50);
    chk("wr_beats_left", bus_q.size(), 32'd0);
    chk("wr_ready",      {31'd0, dif.CMD_READY_O}, 32'd1);
    chk("wr_req_off",    {31'd0, dif.BUS_REQ_O},   32'd0);

    // read burst without increment, delayed response consumer
    rd_q.push_back(16'h0042);
    rd_q.push_back(16'h0043);
    bus_q.push_back('{we: 1'b0, addr: 16'h0100, dout: 16'h0000});
    bus_q.push_back('{we: 1'b0, addr: 16'h0100, dout: 16'h0000});
    rsp_q.push_back(16'h0042);
    rsp_q.push_back(16'h0043);
    send_cmd(OP_RD_MEM, 3'd0, 16'h0100, 16'h0000, 8'd1, 1'b0);
    take_rsp(3);
    take_rsp(3);
    wait_idle(50);
    chk("rd_beats_left", bus_q.size(), 32'd0);
    chk("rd_rsp_left",   rsp_q.size(), 32'd0);
    chk("rd_valid_off",  {31'd0, dif.RSP_VALID_O}, 32'd0);

    // reset in the middle of a stalled read burst
    send_cmd(OP_WR_BKP, 3'd1, 16'h0200, 16'h0, 8'd0, 1'b0);
    dif.PC_I = 16'h0200;
    repeat (2) @(negedge CLK);
    chk("pre_rst_hit", {31'd0, dif.BKP_HIT_O}, 32'd1);
    #1;
    ack_en = 1'b0;
    send_cmd(OP_RD_MEM, 3'd0, 16'h0300, 16'h0000, 8'd3, 1'b1);
    repeat (2) @(negedge CLK);
    chk("stall_req",  {31'd0, dif.BUS_REQ_O},  32'd1);
    chk("stall_addr", {16'd0, dif.BUS_ADDR_O}, 32'h0300);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("mid_rst_busy",  {31'd0, dif.BUSY_O},      32'd0);
    chk("mid_rst_req",   {31'd0, dif.BUS_REQ_O},   32'd0);
    chk("mid_rst_rsp",   {31'd0, dif.RSP_VALID_O}, 32'd0);
    chk("mid_rst_ready", {31'd0, dif.CMD_READY_O}, 32'd1);
    repeat (2) @(negedge CLK);
    chk("mid_rst_bkp_off", {31'd0, dif.BKP_HIT_O}, 32'd0);

`ifdef DEBUG_SEQ_BUS_TIMEOUT_EN
    // unanswered write times out
    send_cmd(OP_WR_MEM, 3'd0, 16'h0400, 16'h1111, 8'd2, 1'b1);
    wait_idle(100);
    chk("to_err",   {31'd0, dif.ERR_O},       32'd1);
    chk("to_ready", {31'd0, dif.CMD_READY_O}, 32'd1);
    chk("to_req",   {31'd0, dif.BUS_REQ_O},   32'd0);
    send_cmd(OP_NOP, 3'd0, 16'h0, 16'h0, 8'd0, 1'b0);
    @(negedge CLK);
    chk("to_err_clr", {31'd0, dif.ERR_O}, 32'd0);
`endif
    #1;
    ack_en = 1'b1;
    repeat (3) @(negedge CLK);
    chk("final_bus_q", bus_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_burst_sequencer.md
Name: debug_burst_sequencer

Overview:
- Multi-cycle successor to the combinational debug op decoder.
- Accepts one debug command per valid/ready handshake. Runs parametrised-length memory read/write bursts with optional address auto-increment, and returns read data through a response handshake.
- Also owns a parametrised breakpoint table with per-slot enables and a PC comparator.
- Sits between the debug port's command shifter and the CPU bus arbiter.

Parameters:
ADDR_WIDTH, 16, width of bus address, breakpoint addresses and PC
DATA_WIDTH, 16, width of bus and response data
NUM_BKP, 4, breakpoint slots (1..8); slot index taken from CMD_ARG_I[2:0]
COUNT_WIDTH, 8, width of burst length field

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
CMD_VALID_I  in  1  command present
CMD_READY_O  out  1  sequencer can accept a command
CMD_OP_I  in  3  0 NOP, 1 WR_BKP, 2 CLR_BKP, 3 RD_MEM, 4 WR_MEM, 5-7 reserved (treated as NOP)
CMD_ARG_I  in  3  breakpoint slot index
CMD_ADDR_I  in  ADDR_WIDTH  start address or breakpoint address
CMD_DATA_I  in  DATA_WIDTH  write data, reused for every beat of WR_MEM
CMD_COUNT_I  in  COUNT_WIDTH  beats minus one
CMD_ADDR_INC_I  in  1  increment address by 1 after each beat
BUS_REQ_O  out  1  bus transfer request
BUS_WE_O  out  1  1 = write
BUS_ADDR_O  out  ADDR_WIDTH  transfer address
BUS_DOUT_O  out  DATA_WIDTH  write data
BUS_DIN_I  in  DATA_WIDTH  read data, valid with BUS_ACK_I
BUS_ACK_I  in  1  transfer complete
RSP_VALID_O  out  1  read data available
RSP_DATA_O  out  DATA_WIDTH  read data
RSP_READY_I  in  1  consumer takes response
PC_I  in  ADDR_WIDTH  current CPU PC
BKP_HIT_O  out  1  registered: PC_I matched an enabled slot last cycle
BUSY_O  out  1  state != IDLE
ERR_O  out  1  sticky error flag, cleared by next accepted command

Behaviour:
- Reset values: all outputs 0, except CMD_READY_O = 1. State = IDLE. All breakpoint enables 0; breakpoint addresses 0. Beat counter 0.
- CMD_READY_O = 1 only in IDLE. A command is accepted on a cycle with CMD_VALID_I & CMD_READY_O; ERR_O clears on acceptance.
- NOP/reserved: consumed in one cycle, state stays IDLE.
- WR_BKP: slot[CMD_ARG_I] gets address CMD_ADDR_I and enable 1, in the accept cycle. CLR_BKP: enable of slot[CMD_ARG_I] cleared. An index >= NUM_BKP sets ERR_O and touches no slot. Both ops stay in IDLE.
- RD_MEM/WR_MEM:
  - On accept, latch address, data, count, inc and op; go to BUS.
  - BUS: BUS_REQ_O=1, BUS_WE_O=op==WR_MEM, BUS_ADDR_O/BUS_DOUT_O from the latches. Hold until BUS_ACK_I.
  - On ACK for a write: if remaining count == 0, go to IDLE; else decrement count, add inc to address, stay in BUS.
  - On ACK for a read: capture BUS_DIN_I into RSP_DATA_O, set RSP_VALID_O, go to RESP. BUS_REQ_O drops the cycle after ACK.
  - RESP: hold RSP_VALID_O/RSP_DATA_O stable until RSP_READY_I. On that cycle, clear RSP_VALID_O; if remaining count == 0 go to IDLE, else decrement, advance address, go to BUS.
- Address wraps modulo 2^ADDR_WIDTH; no error on wrap.
- Latency: first BUS_REQ_O one cycle after accept. Zero-wait ACK gives one beat per cycle for writes, two cycles per beat for reads.
- BKP_HIT_O: registered OR over slots of (enable & addr == PC_I). Active in every state. A slot written in cycle N is compared from cycle N+1.
- RESET mid-burst: returns to IDLE next edge; BUS_REQ_O and RSP_VALID_O drop; breakpoints cleared. An in-flight bus transfer is abandoned.
- BUS_ACK_I outside BUS is ignored.

Optional Feature:
- Macro DEBUG_SEQ_BUS_TIMEOUT_EN.
- Defined: a 6-bit counter runs while in BUS and resets on ACK or state entry. Reaching 63 without ACK forces IDLE, drops BUS_REQ_O, sets ERR_O, and abandons remaining beats without a response.
- Undefined: BUS waits indefinitely; ERR_O is driven only by bad slot index.

Test Plan:
- Reset then idle -> CMD_READY_O=1, BUSY_O=0, BKP_HIT_O=0 with PC_I=0x0000.
- WR_BKP slot 2, addr 0x1234, then PC_I=0x1234 -> BKP_HIT_O=1 one cycle later. CLR_BKP slot 2 -> BKP_HIT_O=0. WR_BKP slot 5 with NUM_BKP=4 -> ERR_O=1, no hit.
- WR_MEM addr 0xFFFE, data 0xA5A5, count 3, inc=1, ACK same cycle -> four writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001, then IDLE.
- RD_MEM addr 0x0100, count 1, inc=0, BUS_DIN_I=0x0042 then 0x0043, RSP_READY_I delayed 3 cycles -> RSP_DATA_O stable at 0x0042 until taken, then 0x0043; both reads at 0x0100.
- RESET asserted in BUS of a 4-beat read -> next cycle IDLE, BUS_REQ_O=0, RSP_VALID_O=0, all breakpoints disabled.
- With DEBUG_SEQ_BUS_TIMEOUT_EN, no ACK for 63 cycles -> ERR_O=1, IDLE, CMD_READY_O=1; next accepted NOP clears ERR_O.
